// File: rtl/prediction_collector_if.sv
// rtl/prediction_collector_if.sv - beat stream carrying one core prediction per handshake
interface prediction_collector_if #(
  parameter int PRED_W = 32,
  parameter int IDX_W  = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [PRED_W-1:0] out_data;
  logic [IDX_W-1:0]  out_core_id;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_core_id,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_core_id,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/prediction_collector.sv
// rtl/prediction_collector.sv - snapshot N core predictions on all_done rise, stream them, report signed argmax
module prediction_collector #(
  parameter int N      = 4,
  parameter int PRED_W = 32,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    all_done,
  input  logic [N*PRED_W-1:0]     predictions,
  prediction_collector_if.master  stream,
  output logic                    best_valid,
  output logic [IDX_W-1:0]        best_core,
  output logic [PRED_W-1:0]       best_value,
  output logic                    busy,
  output logic                    overrun
);
  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [PRED_W-1:0] buf_q [N];
  logic signed [PRED_W-1:0] buf_d [N];
  logic signed [PRED_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]         run_idx_q, run_idx_d;
  logic                     best_valid_q, best_valid_d;
  logic [IDX_W-1:0]         best_core_q, best_core_d;
  logic [PRED_W-1:0]        best_value_q, best_value_d;
  logic                     overrun_q, overrun_d;
  logic                     all_done_q, all_done_d;
  logic                     armed_q, armed_d;
  logic                     out_valid_q, out_valid_d;
  logic [PRED_W-1:0]        out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_core_id_q, out_core_id_d;
  logic                     out_last_q, out_last_d;

  logic                     rise;
  logic                     higher;
  logic signed [PRED_W-1:0] beat;
  logic [IDX_W-1:0]         idx_nxt;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    best_valid_d  = best_valid_q;
    best_core_d   = best_core_q;
    best_value_d  = best_value_q;
    overrun_d     = overrun_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_core_id_d = out_core_id_q;
    out_last_d    = out_last_q;
    all_done_d    = all_done;
    // A level already high when reset releases must fall before it can count as a new batch.
    armed_d       = armed_q | ~all_done;
    rise          = all_done & ~all_done_q & armed_q;
    beat          = buf_q[idx_q];
    higher        = beat > run_max_q;
    idx_nxt       = idx_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          for (int i = 0; i < N; i++) begin
            buf_d[i] = predictions[i*PRED_W +: PRED_W];
          end
          idx_d         = '0;
          best_valid_d  = 1'b0;
          run_max_d     = predictions[PRED_W-1:0];
          run_idx_d     = '0;
          out_valid_d   = 1'b1;
          out_data_d    = predictions[PRED_W-1:0];
          out_core_id_d = '0;
          out_last_d    = 1'b0;
          state_d       = STREAM;
        end
      end
      STREAM: begin
        if (rise) begin
          overrun_d = 1'b1;
        end
        if (stream.out_ready) begin
          if (higher) begin
            run_max_d = beat;
            run_idx_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            best_value_d = higher ? beat : run_max_q;
            best_core_d  = higher ? idx_q : run_idx_q;
            best_valid_d = 1'b1;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            state_d      = IDLE;
          end else begin
            idx_d         = idx_nxt;
            out_data_d    = buf_q[idx_nxt];
            out_core_id_d = idx_nxt;
            out_last_d    = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
      run_max_q     <= '0;
      run_idx_q     <= '0;
      best_valid_q  <= 1'b0;
      best_core_q   <= '0;
      best_value_q  <= '0;
      overrun_q     <= 1'b0;
      all_done_q    <= 1'b0;
      armed_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_core_id_q <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      best_valid_q  <= best_valid_d;
      best_core_q   <= best_core_d;
      best_value_q  <= best_value_d;
      overrun_q     <= overrun_d;
      all_done_q    <= all_done_d;
      armed_q       <= armed_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_core_id_q <= out_core_id_d;
      out_last_q    <= out_last_d;
    end
  end

  assign stream.out_valid   = out_valid_q;
  assign stream.out_data    = out_data_q;
  assign stream.out_core_id = out_core_id_q;
  assign stream.out_last    = out_last_q;
  assign best_valid         = best_valid_q;
  assign best_core          = best_core_q;
  assign best_value         = best_value_q;
  assign busy               = (state_q == STREAM);
  assign overrun            = overrun_q;
endmodule

// File: tb/tb_prediction_collector.sv
// tb/tb_prediction_collector.sv - randomized and directed bench for prediction_collector
module tb_prediction_collector;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           all_done = 1'b0;
  logic [N*W-1:0] predictions = '0;
  logic           best_valid;
  logic [1:0]     best_core;
  logic [W-1:0]   best_value;
  logic           busy;
  logic           overrun;

  prediction_collector_if #(.PRED_W(W), .IDX_W(2)) sif ();

  prediction_collector #(.N(N), .PRED_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .all_done   (all_done),
    .predictions(predictions),
    .stream     (sif),
    .best_valid (best_valid),
    .best_core  (best_core),
    .best_value (best_value),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a batch is a frozen copy of the bus; the result is the first maximum.
  bit                 m_stream, m_best_valid, m_overrun, m_ad_prev, m_armed;
  int                 m_idx;
  logic signed [31:0] m_snap [N];
  logic [1:0]         m_best_core;
  logic signed [31:0] m_best_value;

  function automatic void argmax(input logic signed [31:0] v [N],
                                 output logic [1:0] ci, output logic signed [31:0] cv);
    ci = 0;
    cv = v[0];
    for (int i = 1; i < N; i++) begin
      if (v[i] > cv) begin
        cv = v[i];
        ci = 2'(i);
      end
    end
  endfunction

  task automatic model_reset();
    m_stream = 0; m_best_valid = 0; m_overrun = 0; m_ad_prev = 0; m_armed = 0;
    m_idx = 0; m_best_core = 0; m_best_value = 0;
    for (int i = 0; i < N; i++) m_snap[i] = 0;
  endtask

  initial begin
    bit rise;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        rise = all_done && !m_ad_prev && m_armed;
        if (m_stream) begin
          if (rise) m_overrun = 1;
          if (sif.out_ready) begin
            if (m_idx == N - 1) begin
              m_stream = 0;
              m_best_valid = 1;
              argmax(m_snap, m_best_core, m_best_value);
            end else begin
              m_idx++;
            end
          end
        end else if (rise) begin
          for (int i = 0; i < N; i++) m_snap[i] = predictions[i*W +: W];
          m_stream = 1;
          m_idx = 0;
          m_best_valid = 0;
        end
        m_ad_prev = all_done;
        if (!all_done) m_armed = 1;
      end
    end
  end

  // Accepted beats seen on the DUT, for literal pins of the model.
  logic [31:0] beat_data [$];
  int          beat_id   [$];
  int          beat_cyc  [$];
  int          beat_last [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_valid", 32'(sif.out_valid), 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_best", {best_valid, 7'(best_core), 24'(best_value)}, 0);
        chk("rst_flags", {busy, overrun, sif.out_last, 29'(sif.out_core_id)}, 0);
      end else begin
        chk("out_valid", 32'(sif.out_valid), 32'(m_stream));
        chk("busy", 32'(busy), 32'(m_stream));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("best_valid", 32'(best_valid), 32'(m_best_valid));
        if (m_best_valid) begin
          chk("best_core", 32'(best_core), 32'(m_best_core));
          chk("best_value", best_value, m_best_value);
        end
        if (m_stream) begin
          chk("out_data", sif.out_data, m_snap[m_idx]);
          chk("out_core_id", 32'(sif.out_core_id), 32'(m_idx));
          chk("out_last", 32'(sif.out_last), 32'(m_idx == N - 1));
        end
        if (sif.out_valid && sif.out_ready) begin
          beat_data.push_back(sif.out_data);
          beat_id.push_back(int'(sif.out_core_id));
          beat_last.push_back(int'(sif.out_last));
          beat_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_preds(input logic [31:0] a, b, c, d);
    predictions = {d, c, b, a};
  endtask

  task automatic clear_beats();
    beat_data.delete(); beat_id.delete(); beat_cyc.delete(); beat_last.delete();
  endtask

  task automatic pin_beats(input string nm, input logic [31:0] a, b, c, d);
    logic [31:0] e [N];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    chk({nm, "_count"}, 32'(beat_data.size()), N);
    for (int i = 0; i < N && i < beat_data.size(); i++) begin
      chk({nm, "_data"}, beat_data[i], e[i]);
      chk({nm, "_id"}, 32'(beat_id[i]), 32'(i));
      chk({nm, "_last"}, 32'(beat_last[i]), 32'(i == N - 1));
    end
  endtask

  initial begin
    sif.out_ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // Basic batch, ready always high: beats on consecutive cycles.
    set_preds(5, -3, 12, 7);
    sif.out_ready = 1'b1;
    clear_beats();
    all_done = 1'b1;
    step(8);
    pin_beats("t1", 5, -3, 12, 7);
    if (beat_cyc.size() == N) chk("t1_consecutive", 32'(beat_cyc[N-1] - beat_cyc[0]), N - 1);
    chk("t1_best_core", 32'(best_core), 2);
    chk("t1_best_value", best_value, 12);
    chk("t1_best_valid", 32'(best_valid), 1);

    // Same batch with stalls.
    all_done = 1'b0;
    step(2);
    clear_beats();
    all_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sif.out_ready = (i % 3 == 0);
      step(1);
    end
    sif.out_ready = 1'b1;
    step(3);
    pin_beats("t2", 5, -3, 12, 7);
    chk("t2_best_core", 32'(best_core), 2);
    chk("t2_best_value", best_value, 12);

    // Signed ties and extremes.
    all_done = 1'b0;
    step(2);
    set_preds(-8, -2, -2, -9);
    all_done = 1'b1;
    step(7);
    chk("t3_tie_core", 32'(best_core), 1);
    chk("t3_tie_value", best_value, 32'hFFFF_FFFE);
    all_done = 1'b0;
    step(2);
    set_preds(32'h7FFF_FFFF, 32'h8000_0000, 0, 32'h7FFF_FFFF);
    all_done = 1'b1;
    step(7);
    chk("t3_ext_core", 32'(best_core), 0);
    chk("t3_ext_value", best_value, 32'h7FFF_FFFF);

    // Rise while streaming is an overrun and leaves the buffer alone.
    all_done = 1'b0;
    sif.out_ready = 1'b0;
    step(2);
    clear_beats();
    set_preds(1, 2, 3, 4);
    all_done = 1'b1;
    step(2);
    all_done = 1'b0;
    step(1);
    set_preds(40, 30, 20, 10);
    all_done = 1'b1;
    step(1);
    sif.out_ready = 1'b1;
    step(6);
    pin_beats("t4", 1, 2, 3, 4);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_best_core", 32'(best_core), 3);
    all_done = 1'b0;
    step(1);
    all_done = 1'b1;
    step(7);
    chk("t4_new_core", 32'(best_core), 0);
    chk("t4_new_value", best_value, 40);
    chk("t4_overrun_held", 32'(overrun), 1);

    // Asynchronous reset mid-stream, then no capture while all_done stays high.
    all_done = 1'b0;
    step(2);
    set_preds(9, 8, 7, 6);
    all_done = 1'b1;
    step(2);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_valid", 32'(sif.out_valid), 0);
    chk("t5_async_data", sif.out_data, 0);
    chk("t5_async_overrun", 32'(overrun), 0);
    step(2);
    rst = 1'b1;
    clear_beats();
    step(10);
    chk("t5_no_capture", 32'(beat_data.size()), 0);
    chk("t5_no_best", 32'(best_valid), 0);
    all_done = 1'b0;
    step(1);
    all_done = 1'b1;
    step(7);
    pin_beats("t5", 9, 8, 7, 6);

    // Level held high: only one capture.
    all_done = 1'b0;
    step(2);
    clear_beats();
    all_done = 1'b1;
    step(100);
    chk("t6_beats", 32'(beat_data.size()), N);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_preds($urandom, $urandom, $urandom_range(0, 3) - 2, $urandom);
      sif.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) all_done = ~all_done;
      if (i == 300) begin
        rst = 1'b0;
        step(2);
        rst = 1'b1;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
